ball_hit_detect: RTL and testbench

Frame-rate ball-pair contact detector for the billiards engine. Once per frame it takes a snapshot of two balls' centres and magnitude/direction velocities, computes squared centre distance and closing speed with one shared multiplier, and emits a one-cycle `hit` pulse when the balls touch and are approaching. It sits directly upstream of the ball-pair velocity-update block and supplies the centre-offset vector that block needs for its sin/cos terms.

---
 rtl/dang9_pkg.sv | 21 ++
 rtl/ball_hit_detect_if.sv | 25 ++
 rtl/mag2signed.sv | 13 +
 rtl/ball_hit_detect.sv | 123 ++++++++++++
 tb/tb_ball_hit_detect.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dang9_pkg.sv
// Shared constants and types for the billiards ball-pair contact detector.
package dang9_pkg;
  localparam int BALL_SIZE = 30;
  localparam int COORD_W   = 10;
  localparam int SCOORD_W  = 11;
  localparam int RVEL_W    = 12;
  localparam int MULT_W    = 12;
  localparam int DIST2_W   = 21;
  localparam int DOT_W     = 23;
  localparam logic [DIST2_W-1:0] D2 = DIST2_W'(BALL_SIZE * BALL_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIFF,
    ST_MX,
    ST_MY,
    ST_DX,
    ST_DY,
    ST_CMP
  } state_t;
endpackage

// File: rtl/ball_hit_detect_if.sv
// Frame snapshot inputs and contact results of the ball-pair hit detector.
interface ball_hit_detect_if;
  import dang9_pkg::*;

  logic                       frame_tick;
  logic [COORD_W-1:0]         xBall_a, yBall_a, xBall_b, yBall_b;
  logic [COORD_W-1:0]         Vx_a, Vy_a, Vx_b, Vy_b;
  logic                       Dx_a, Dy_a, Dx_b, Dy_b;
  logic                       hit;
  logic                       busy;
  logic signed [SCOORD_W-1:0] dx_ab, dy_ab;
  logic [DIST2_W-1:0]         dist2;

  modport master (
    output frame_tick, xBall_a, yBall_a, xBall_b, yBall_b,
    output Vx_a, Vy_a, Vx_b, Vy_b, Dx_a, Dy_a, Dx_b, Dy_b,
    input  hit, busy, dx_ab, dy_ab, dist2
  );

  modport slave (
    input  frame_tick, xBall_a, yBall_a, xBall_b, yBall_b,
    input  Vx_a, Vy_a, Vx_b, Vy_b, Dx_a, Dy_a, Dx_b, Dy_b,
    output hit, busy, dx_ab, dy_ab, dist2
  );
endinterface

// File: rtl/mag2signed.sv
// Speed magnitude plus direction bit (1 = +axis) to signed velocity.
module mag2signed
  import dang9_pkg::*;
(
  input  logic [COORD_W-1:0]         mag,
  input  logic                       dir,
  output logic signed [SCOORD_W-1:0] val
);
  logic signed [SCOORD_W-1:0] mag_s;

  assign mag_s = signed'({1'b0, mag});
  assign val   = dir ? mag_s : -mag_s;
endmodule

// File: rtl/ball_hit_detect.sv
// Per-frame ball-pair contact detector: squared distance and closing speed
// computed sequentially through one shared 12x12 signed multiplier.
module ball_hit_detect
  import dang9_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ball_hit_detect_if.slave bus
);
  state_t state, state_nxt;

  logic [COORD_W-1:0]         xa_q, ya_q, xb_q, yb_q;
  logic [COORD_W-1:0]         vxa_q, vya_q, vxb_q, vyb_q;
  logic                       dxa_q, dya_q, dxb_q, dyb_q;
  logic signed [SCOORD_W-1:0] svxa, svya, svxb, svyb;
  logic signed [RVEL_W-1:0]   rvx_q, rvy_q;
  logic [DIST2_W-1:0]         acc_q;
  logic signed [DOT_W-1:0]    dot_q;
  logic signed [SCOORD_W-1:0] dx_q, dy_q;
  logic [DIST2_W-1:0]         dist2_q;
  logic                       hit_q, armed_q, hit_nxt;
  logic signed [MULT_W-1:0]   op_a, op_b, dx_e, dy_e;
  logic signed [DOT_W-1:0]    prod;

  mag2signed u_vxa (.mag(vxa_q), .dir(dxa_q), .val(svxa));
  mag2signed u_vya (.mag(vya_q), .dir(dya_q), .val(svya));
  mag2signed u_vxb (.mag(vxb_q), .dir(dxb_q), .val(svxb));
  mag2signed u_vyb (.mag(vyb_q), .dir(dyb_q), .val(svyb));

  assign dx_e = MULT_W'(dx_q);
  assign dy_e = MULT_W'(dy_q);
  // Operands stay 12-bit signed; widened only so the product lands at dot width.
  assign prod = DOT_W'(op_a) * DOT_W'(op_b);

  assign hit_nxt = armed_q && (dist2_q <= D2) && dot_q[DOT_W-1];

  always_comb begin
    state_nxt = state;
    op_a      = '0;
    op_b      = '0;
    case (state)
      ST_IDLE: if (bus.frame_tick) state_nxt = ST_DIFF;
      ST_DIFF: state_nxt = ST_MX;
      ST_MX: begin
        op_a      = dx_e;
        op_b      = dx_e;
        state_nxt = ST_MY;
      end
      ST_MY: begin
        op_a      = dy_e;
        op_b      = dy_e;
        state_nxt = ST_DX;
      end
      ST_DX: begin
        op_a      = dx_e;
        op_b      = rvx_q;
        state_nxt = ST_DY;
      end
      ST_DY: begin
        op_a      = dy_e;
        op_b      = rvy_q;
        state_nxt = ST_CMP;
      end
      ST_CMP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      hit_q   <= 1'b0;
      armed_q <= 1'b1;
      dx_q    <= '0;
      dy_q    <= '0;
      dist2_q <= '0;
    end else begin
      state <= state_nxt;
      hit_q <= 1'b0;
      if (state == ST_DIFF) begin
        dx_q <= signed'({1'b0, xb_q}) - signed'({1'b0, xa_q});
        dy_q <= signed'({1'b0, yb_q}) - signed'({1'b0, ya_q});
      end
      if (state == ST_MY) dist2_q <= acc_q + prod[DIST2_W-1:0];
      // Armed only re-arms after a frame that sees the balls clearly apart.
      if (state == ST_CMP) begin
        hit_q <= hit_nxt;
        if (hit_nxt)           armed_q <= 1'b0;
        else if (dist2_q > D2) armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.frame_tick) begin
      xa_q  <= bus.xBall_a;
      ya_q  <= bus.yBall_a;
      xb_q  <= bus.xBall_b;
      yb_q  <= bus.yBall_b;
      vxa_q <= bus.Vx_a;
      vya_q <= bus.Vy_a;
      vxb_q <= bus.Vx_b;
      vyb_q <= bus.Vy_b;
      dxa_q <= bus.Dx_a;
      dya_q <= bus.Dy_a;
      dxb_q <= bus.Dx_b;
      dyb_q <= bus.Dy_b;
    end
    if (state == ST_DIFF) begin
      rvx_q <= RVEL_W'(svxb) - RVEL_W'(svxa);
      rvy_q <= RVEL_W'(svyb) - RVEL_W'(svya);
    end
    if (state == ST_MX) acc_q <= prod[DIST2_W-1:0];
    if (state == ST_DX) dot_q <= prod;
    if (state == ST_DY) dot_q <= dot_q + prod;
  end

  assign bus.hit   = hit_q;
  assign bus.busy  = (state != ST_IDLE);
  assign bus.dx_ab = dx_q;
  assign bus.dy_ab = dy_q;
  assign bus.dist2 = dist2_q;
endmodule

// File: tb/tb_ball_hit_detect.sv
// Bench for ball_hit_detect: directed frames plus randomized frames against a behavioural model.
module tb_ball_hit_detect;
  import dang9_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ball_hit_detect_if bus ();

  ball_hit_detect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xa, ya, xb, yb;
    int vxa, vya, vxb, vyb;
    bit dxa, dya, dxb, dyb;
  } frame_t;

  int vectors     = 0;
  int miscompares = 0;
  bit m_armed     = 1'b1;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic frame_t mk(input int xa, ya, xb, yb, vxa, vya, vxb, vyb,
                                input bit dxa, dya, dxb, dyb);
    frame_t f;
    f.xa = xa;   f.ya = ya;   f.xb = xb;   f.yb = yb;
    f.vxa = vxa; f.vya = vya; f.vxb = vxb; f.vyb = vyb;
    f.dxa = dxa; f.dya = dya; f.dxb = dxb; f.dyb = dyb;
    return f;
  endfunction

  task automatic apply_tick(input frame_t f);
    @(negedge clk);
    bus.xBall_a = 10'(f.xa);  bus.yBall_a = 10'(f.ya);
    bus.xBall_b = 10'(f.xb);  bus.yBall_b = 10'(f.yb);
    bus.Vx_a = 10'(f.vxa);    bus.Vy_a = 10'(f.vya);
    bus.Vx_b = 10'(f.vxb);    bus.Vy_b = 10'(f.vyb);
    bus.Dx_a = f.dxa;  bus.Dy_a = f.dya;
    bus.Dx_b = f.dxb;  bus.Dy_b = f.dyb;
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
  endtask

  // One full frame; extra_k >= 0 raises a spurious tick (with scrambled inputs) in that cycle.
  task automatic run(input string tag, input frame_t f, input int extra_k);
    int dx, dy, rvx, rvy, d2, dot;
    bit exp_hit;
    dx  = f.xb - f.xa;
    dy  = f.yb - f.ya;
    rvx = (f.dxb ? f.vxb : -f.vxb) - (f.dxa ? f.vxa : -f.vxa);
    rvy = (f.dyb ? f.vyb : -f.vyb) - (f.dya ? f.vya : -f.vya);
    d2  = dx * dx + dy * dy;
    dot = dx * rvx + dy * rvy;
    exp_hit = m_armed && (d2 <= BALL_SIZE * BALL_SIZE) && (dot < 0);

    apply_tick(f);
    for (int k = 0; k < 7; k++) begin
      chk({tag, ".busy"}, bus.busy, (k < 6));
      chk({tag, ".hit"},  bus.hit,  (k == 6) && exp_hit);
      if (k == extra_k) begin
        bus.frame_tick = 1'b1;
        bus.xBall_b    = bus.xBall_b ^ 10'h155;
        bus.Vx_a       = bus.Vx_a ^ 10'h2AA;
      end
      if (k < 6) begin
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
      end
    end
    chk({tag, ".dx_ab"}, bus.dx_ab, dx);
    chk({tag, ".dy_ab"}, bus.dy_ab, dy);
    chk({tag, ".dist2"}, bus.dist2, d2);

    if (exp_hit) m_armed = 1'b0;
    else if (d2 > BALL_SIZE * BALL_SIZE) m_armed = 1'b1;

    @(posedge clk);
    #1;
    chk({tag, ".hit_after"},  bus.hit,  0);
    chk({tag, ".busy_after"}, bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    frame_t f;
    bus.frame_tick = 1'b0;
    bus.xBall_a = '0; bus.yBall_a = '0; bus.xBall_b = '0; bus.yBall_b = '0;
    bus.Vx_a = '0; bus.Vy_a = '0; bus.Vx_b = '0; bus.Vy_b = '0;
    bus.Dx_a = 1'b0; bus.Dy_a = 1'b0; bus.Dx_b = 1'b0; bus.Dy_b = 1'b0;

    #22;
    chk("reset.hit",   bus.hit,   0);
    chk("reset.busy",  bus.busy,  0);
    chk("reset.dx_ab", bus.dx_ab, 0);
    chk("reset.dy_ab", bus.dy_ab, 0);
    chk("reset.dist2", bus.dist2, 0);
    @(negedge clk);
    rst = 1'b1;
    m_armed = 1'b1;

    run("approach",   mk(100, 100, 120, 100, 3, 0, 0, 0, 1, 0, 0, 0), -1);
    run("separating", mk(100, 100, 120, 100, 3, 0, 0, 0, 0, 0, 0, 0), -1);
    run("apart131",   mk(100, 100, 131, 100, 1, 0, 0, 0, 1, 0, 0, 0), -1);
    run("contact130", mk(100, 100, 130, 100, 1, 0, 0, 0, 1, 0, 0, 0), -1);
    run("retrigger",  mk(100, 100, 125, 100, 4, 0, 0, 0, 1, 0, 0, 0), -1);
    run("rearm200",   mk(100, 100, 200, 100, 4, 0, 0, 0, 1, 0, 0, 0), -1);
    run("rearm_hit",  mk(100, 100, 125, 100, 4, 0, 0, 0, 1, 0, 0, 0), -1);
    run("extreme",    mk(0, 0, 1023, 1023, 0, 0, 0, 0, 0, 0, 0, 0), -1);
    run("extreme_sw", mk(1023, 1023, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), -1);
    run("coincident", mk(300, 300, 300, 300, 5, 5, 5, 5, 1, 1, 0, 0), -1);
    run("tangential", mk(100, 100, 120, 100, 0, 4, 0, 0, 0, 1, 0, 0), -1);
    run("still",      mk(100, 100, 110, 110, 0, 0, 0, 0, 0, 0, 0, 0), -1);

    // Spurious ticks while busy and in the CMP cycle
    run("tick_busy",  mk(100, 100, 120, 100, 3, 0, 0, 0, 1, 0, 0, 0), 2);
    run("tick_cmp",   mk(500, 500, 600, 500, 3, 0, 0, 0, 1, 0, 0, 0), 5);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("quiet.busy", bus.busy, 0);
      chk("quiet.hit",  bus.hit,  0);
    end

    // Make armed clear, then abort a frame in MY with reset
    run("pre_abort",  mk(100, 100, 120, 100, 3, 0, 0, 0, 1, 0, 0, 0), -1);
    apply_tick(mk(200, 200, 220, 200, 3, 0, 0, 0, 1, 0, 0, 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort.hit",   bus.hit,   0);
    chk("abort.busy",  bus.busy,  0);
    chk("abort.dx_ab", bus.dx_ab, 0);
    chk("abort.dy_ab", bus.dy_ab, 0);
    chk("abort.dist2", bus.dist2, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("abort_hold.hit", bus.hit, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    m_armed = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst.hit",  bus.hit,  0);
      chk("post_rst.busy", bus.busy, 0);
    end
    run("post_abort", mk(100, 100, 120, 100, 3, 0, 0, 0, 1, 0, 0, 0), -1);

    for (int n = 0; n < 60; n++) begin
      if (n % 5 == 4) begin
        f.xa = int'($urandom_range(0, 1023)); f.ya = int'($urandom_range(0, 1023));
        f.xb = int'($urandom_range(0, 1023)); f.yb = int'($urandom_range(0, 1023));
      end else begin
        f.xa = int'($urandom_range(40, 980)); f.ya = int'($urandom_range(40, 980));
        f.xb = f.xa + int'($urandom_range(0, 60)) - 30;
        f.yb = f.ya + int'($urandom_range(0, 60)) - 30;
      end
      if ($urandom_range(0, 3) == 0) begin
        f.vxa = int'($urandom_range(0, 1023)); f.vya = int'($urandom_range(0, 1023));
        f.vxb = int'($urandom_range(0, 1023)); f.vyb = int'($urandom_range(0, 1023));
      end else begin
        f.vxa = int'($urandom_range(0, 5)); f.vya = int'($urandom_range(0, 5));
        f.vxb = int'($urandom_range(0, 5)); f.vyb = int'($urandom_range(0, 5));
      end
      f.dxa = 1'($urandom); f.dya = 1'($urandom);
      f.dxb = 1'($urandom); f.dyb = 1'($urandom);
      run("random", f, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
